cmplx_mult_seq: RTL and testbench

//  Parametrised successor to the board-level complex multiplier. Loads four signed WIDTH-bit

---
 rtl/cmplx_mult_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_cmplx_mult_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmplx_mult_seq.sv
// Sequential complex multiplier: four operand words are loaded one per handshake edge, then the
// product a*q (or a*conj(q)) is rounded, range-fitted and shown re-then-im on the LED word.
module cmplx_mult_seq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned FRAC_BITS   = 0,
  parameter bit          SATURATE    = 1'b1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MULT_LAT    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             handshake,
  input  logic [WIDTH-1:0] data_in,
  input  logic             conj_en,
  output logic [WIDTH-1:0] led,
  output logic [2:0]       state_o,
  output logic             busy,
  output logic             ovf,
  output logic             dropped
);

  localparam logic [2:0] LD_RE_A = 3'd0;
  localparam logic [2:0] LD_IM_A = 3'd1;
  localparam logic [2:0] LD_RE_Q = 3'd2;
  localparam logic [2:0] LD_IM_Q = 3'd3;
  localparam logic [2:0] CALC    = 3'd4;
  localparam logic [2:0] SHOW_RE = 3'd5;
  localparam logic [2:0] SHOW_IM = 3'd6;

  // One spare bit over the 2*WIDTH+1 full-precision sum so the rounding add cannot overflow.
  localparam int unsigned PW     = 2 * WIDTH + 2;
  localparam int unsigned CW     = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
  localparam int unsigned RND_SH = (FRAC_BITS == 0) ? 0 : FRAC_BITS - 1;

  localparam logic signed [PW-1:0] RND  = (FRAC_BITS == 0) ? PW'(0) : (PW'(1) << RND_SH);
  localparam logic signed [PW-1:0] MAXV = {{(PW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
  localparam logic [WIDTH-1:0]     MAXW = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0]     MINW = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic [CW-1:0]        LAST = CW'(MULT_LAT - 1);

  // ---------------------------------------------------------------------------------------------
  // Handshake synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_q_d;
  logic                   hs_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      sync_q_d <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], handshake};
      sync_q_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign hs_edge = sync_q[SYNC_STAGES-1] & ~sync_q_d;

  // ---------------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------------
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cap_en;
  logic          calc_done;

  assign calc_done = (state_q == CALC) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_en  = 1'b0;
    case (state_q)
      LD_RE_A: if (hs_edge) begin state_d = LD_IM_A; cap_en = 1'b1; end
      LD_IM_A: if (hs_edge) begin state_d = LD_RE_Q; cap_en = 1'b1; end
      LD_RE_Q: if (hs_edge) begin state_d = LD_IM_Q; cap_en = 1'b1; end
      LD_IM_Q: begin
        if (hs_edge) begin
          state_d = CALC;
          cnt_d   = '0;
          cap_en  = 1'b1;
        end
      end
      CALC: begin
        if (cnt_q == LAST) begin
          state_d = SHOW_RE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHOW_RE: if (hs_edge) state_d = SHOW_IM;
      // Leaving the result display doubles as loading the next re_a.
      SHOW_IM: if (hs_edge) begin state_d = LD_IM_A; cap_en = 1'b1; end
      default: state_d = LD_RE_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LD_RE_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------------------------
  logic signed [WIDTH-1:0] re_a_q, im_a_q, re_q_q, im_q_q;
  logic        [WIDTH-1:0] last_q;
  logic                    conj_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      re_a_q <= '0;
      im_a_q <= '0;
      re_q_q <= '0;
      im_q_q <= '0;
      last_q <= '0;
      conj_q <= 1'b0;
    end else if (cap_en) begin
      last_q <= data_in;
      case (state_q)
        LD_RE_A, SHOW_IM: re_a_q <= data_in;
        LD_IM_A:          im_a_q <= data_in;
        LD_RE_Q:          re_q_q <= data_in;
        LD_IM_Q: begin
          im_q_q <= data_in;
          conj_q <= conj_en;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Arithmetic: full-precision products, round half up, fit to WIDTH
  // ---------------------------------------------------------------------------------------------
  logic signed [PW-1:0] ar_x, ai_x, qr_x, qi_x;
  logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
  logic signed [PW-1:0] sum_re, sum_im, rnd_re, rnd_im;
  logic                 ovf_re_c, ovf_im_c;
  logic [WIDTH-1:0]     res_re_c, res_im_c;

  always_comb begin
    ar_x = PW'(re_a_q);
    ai_x = PW'(im_a_q);
    qr_x = PW'(re_q_q);
    qi_x = PW'(im_q_q);

    p_rr = ar_x * qr_x;
    p_ii = ai_x * qi_x;
    p_ir = ai_x * qr_x;
    p_ri = ar_x * qi_x;

    sum_re = conj_q ? (p_rr + p_ii) : (p_rr - p_ii);
    sum_im = conj_q ? (p_ir - p_ri) : (p_ir + p_ri);

    rnd_re = (sum_re + RND) >>> FRAC_BITS;
    rnd_im = (sum_im + RND) >>> FRAC_BITS;

    ovf_re_c = (rnd_re > MAXV) || (rnd_re < MINV);
    ovf_im_c = (rnd_im > MAXV) || (rnd_im < MINV);

    res_re_c = rnd_re[WIDTH-1:0];
    res_im_c = rnd_im[WIDTH-1:0];
    if (SATURATE) begin
      if (rnd_re > MAXV)      res_re_c = MAXW;
      else if (rnd_re < MINV) res_re_c = MINW;
      if (rnd_im > MAXV)      res_im_c = MAXW;
      else if (rnd_im < MINV) res_im_c = MINW;
    end
  end

  logic [WIDTH-1:0] res_re_q, res_im_q;
  logic             ovf_re_q, ovf_im_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_re_q <= '0;
      res_im_q <= '0;
      ovf_re_q <= 1'b0;
      ovf_im_q <= 1'b0;
    end else if (calc_done) begin
      res_re_q <= res_re_c;
      res_im_q <= res_im_c;
      ovf_re_q <= ovf_re_c;
      ovf_im_q <= ovf_im_c;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Display outputs
  // ---------------------------------------------------------------------------------------------
  logic [WIDTH-1:0] led_q, led_d;
  logic             ovf_q, ovf_d;
  logic             dropped_q;

  always_comb begin
    led_d = led_q;
    ovf_d = 1'b0;
    case (state_q)
      LD_RE_A, LD_IM_A, LD_RE_Q, LD_IM_Q: led_d = last_q;
      CALC:    led_d = led_q;
      SHOW_RE: begin
        led_d = res_re_q;
        ovf_d = ovf_re_q;
      end
      SHOW_IM: begin
        led_d = res_im_q;
        ovf_d = ovf_im_q;
      end
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      ovf_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      led_q <= led_d;
      ovf_q <= ovf_d;
      if ((state_q == CALC) && hs_edge) dropped_q <= 1'b1;
    end
  end

  assign led     = led_q;
  assign ovf     = ovf_q;
  assign dropped = dropped_q;
  assign state_o = state_q;
  assign busy    = (state_q == CALC);

endmodule

// File: tb/tb_cmplx_mult_seq.sv
// Bench for cmplx_mult_seq: three instances (saturating, wrapping, FRAC_BITS=4) driven in lockstep,
// checked against a table of known results and an integer-arithmetic reference model.
module tb_cmplx_mult_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       handshake;
  logic [7:0] data_in;
  logic       conj_en;

  logic [7:0] led     [3];
  logic [2:0] st      [3];
  logic       busy    [3];
  logic       ovf     [3];
  logic       dropped [3];

  int n_pass  = 0;
  int n_total = 0;

  int got_re [3];
  int got_im [3];
  int got_ore[3];
  int got_oim[3];

  always #5 clk = ~clk;

  cmplx_mult_seq #(.WIDTH(8), .FRAC_BITS(0), .SATURATE(1'b1), .SYNC_STAGES(2), .MULT_LAT(3))
    u_sat (.clk(clk), .reset(reset), .handshake(handshake), .data_in(data_in),
           .conj_en(conj_en), .led(led[0]), .state_o(st[0]), .busy(busy[0]), .ovf(ovf[0]),
           .dropped(dropped[0]));

  cmplx_mult_seq #(.WIDTH(8), .FRAC_BITS(0), .SATURATE(1'b0), .SYNC_STAGES(2), .MULT_LAT(3))
    u_wrap (.clk(clk), .reset(reset), .handshake(handshake), .data_in(data_in),
            .conj_en(conj_en), .led(led[1]), .state_o(st[1]), .busy(busy[1]), .ovf(ovf[1]),
            .dropped(dropped[1]));

  cmplx_mult_seq #(.WIDTH(8), .FRAC_BITS(4), .SATURATE(1'b1), .SYNC_STAGES(2), .MULT_LAT(3))
    u_frac (.clk(clk), .reset(reset), .handshake(handshake), .data_in(data_in),
            .conj_en(conj_en), .led(led[2]), .state_o(st[2]), .busy(busy[2]), .ovf(ovf[2]),
            .dropped(dropped[2]));

  typedef struct {
    logic [7:0] ar, ai, qr, qi;
    bit         cj;
    int         inst;
    int         re, im;
    int         ore, oim;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int frac_of(input int k);
    return (k == 2) ? 4 : 0;
  endfunction

  function automatic bit sat_of(input int k);
    return (k != 1);
  endfunction

  function automatic longint sx(input logic [7:0] b);
    return longint'($signed(b));
  endfunction

  // Round half up via floor division, then clamp or keep low byte.
  function automatic void fit(input longint v, input int frac, input bit sat,
                              output int res, output int o);
    longint d, n, q;
    if (frac > 0) begin
      d = longint'(1) << frac;
      n = v + d / 2;
      q = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
    end else begin
      q = v;
    end
    o = ((q > 127) || (q < -128)) ? 1 : 0;
    if (sat && q > 127) q = 127;
    else if (sat && q < -128) q = -128;
    res = int'(q & 64'hFF);
  endfunction

  function automatic void model(input logic [7:0] ar, ai, qr, qi, input bit cj, input int k,
                                output int re, im, ore, oim);
    longint vre, vim;
    vre = cj ? sx(ar) * sx(qr) + sx(ai) * sx(qi) : sx(ar) * sx(qr) - sx(ai) * sx(qi);
    vim = cj ? sx(ai) * sx(qr) - sx(ar) * sx(qi) : sx(ai) * sx(qr) + sx(ar) * sx(qi);
    fit(vre, frac_of(k), sat_of(k), re, ore);
    fit(vim, frac_of(k), sat_of(k), im, oim);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] d);
    @(negedge clk);
    data_in   = d;
    handshake = 1'b1;
    repeat (4) @(negedge clk);
    handshake = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Full transaction ending in SHOW_IM; drop_edge adds a second strobe that lands inside CALC.
  task automatic run_op(input logic [7:0] ar, ai, qr, qi, input bit cj, input bit drop_edge);
    int busy_cnt;
    pulse(ar);
    check("load_re_a_state", int'(st[0]), 1);
    check("load_re_a_led", int'(led[0]), int'(ar));
    pulse(ai);
    pulse(qr);
    check("load_re_q_led", int'(led[0]), int'(qr));
    @(negedge clk);
    data_in   = qi;
    conj_en   = cj;
    handshake = 1'b1;
    busy_cnt  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy[0]) busy_cnt++;
      if (drop_edge) begin
        if (i == 0) handshake = 1'b0;
        if (i == 1) handshake = 1'b1;
        if (i == 2) handshake = 1'b0;
      end else if (i == 3) begin
        handshake = 1'b0;
      end
    end
    check("busy_cycles", busy_cnt, 3);
    check("show_re_state", int'(st[0]), 5);
    for (int k = 0; k < 3; k++) begin
      got_re[k]  = int'(led[k]);
      got_ore[k] = int'(ovf[k]);
    end
    pulse(8'hA5);
    check("show_im_state", int'(st[0]), 6);
    for (int k = 0; k < 3; k++) begin
      got_im[k]  = int'(led[k]);
      got_oim[k] = int'(ovf[k]);
    end
  endtask

  vec_t tbl[9];

  initial begin
    int mre, mim, more, moim;
    logic [7:0] r_ar, r_ai, r_qr, r_qi;
    bit r_cj;

    tbl[0] = '{8'd3,   8'd2, 8'd4,   8'd5, 1'b0, 0, 8'h02, 8'h17, 0, 0};
    tbl[1] = '{8'd3,   8'd2, 8'd4,   8'd5, 1'b1, 0, 8'h16, 8'hF9, 0, 0};
    tbl[2] = '{8'd127, 8'd0, 8'd127, 8'd0, 1'b0, 0, 8'h7F, 8'h00, 1, 0};
    tbl[3] = '{8'd127, 8'd0, 8'd127, 8'd0, 1'b0, 1, 8'h01, 8'h00, 1, 0};
    tbl[4] = '{8'h80,  8'd0, 8'h80,  8'd0, 1'b0, 0, 8'h7F, 8'h00, 1, 0};
    tbl[5] = '{8'h10,  8'd0, 8'h18,  8'd0, 1'b0, 2, 8'h18, 8'h00, 0, 0};
    tbl[6] = '{8'h01,  8'd0, 8'h08,  8'd0, 1'b0, 2, 8'h01, 8'h00, 0, 0};
    tbl[7] = '{8'hFF,  8'd0, 8'h08,  8'd0, 1'b0, 2, 8'h00, 8'h00, 0, 0};
    tbl[8] = '{8'h80,  8'd0, 8'd127, 8'd0, 1'b0, 0, 8'h80, 8'h00, 1, 0};

    reset     = 1'b1;
    handshake = 1'b0;
    data_in   = 8'h00;
    conj_en   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_led%0d", k), int'(led[k]), 0);
      check($sformatf("reset_state%0d", k), int'(st[k]), 0);
      check($sformatf("reset_busy%0d", k), int'(busy[k]), 0);
      check($sformatf("reset_ovf%0d", k), int'(ovf[k]), 0);
      check($sformatf("reset_dropped%0d", k), int'(dropped[k]), 0);
    end

    // Long strobe: a single advance only.
    @(negedge clk);
    data_in   = 8'h33;
    handshake = 1'b1;
    repeat (50) @(negedge clk);
    handshake = 1'b0;
    repeat (6) @(negedge clk);
    check("held_high_state", int'(st[0]), 1);
    check("held_high_led", int'(led[0]), 8'h33);
    do_reset();

    for (int v = 0; v < 9; v++) begin
      run_op(tbl[v].ar, tbl[v].ai, tbl[v].qr, tbl[v].qi, tbl[v].cj, 1'b0);
      check($sformatf("tbl%0d_re", v), got_re[tbl[v].inst], tbl[v].re);
      check($sformatf("tbl%0d_ovf_re", v), got_ore[tbl[v].inst], tbl[v].ore);
      check($sformatf("tbl%0d_im", v), got_im[tbl[v].inst], tbl[v].im);
      check($sformatf("tbl%0d_ovf_im", v), got_oim[tbl[v].inst], tbl[v].oim);
    end
    // Next re_a loaded straight out of SHOW_IM.
    pulse(8'h05);
    check("show_im_reload_state", int'(st[0]), 1);
    check("show_im_reload_led", int'(led[0]), 8'h05);
    do_reset();
    check("dropped_clear", int'(dropped[0]), 0);

    // Strobe during CALC is dropped and flagged, result untouched.
    run_op(8'd3, 8'd2, 8'd4, 8'd5, 1'b0, 1'b1);
    check("drop_flag", int'(dropped[0]), 1);
    check("drop_re", got_re[0], 8'h02);
    check("drop_im", got_im[0], 8'h17);

    // Reset in LD_RE_Q aborts the operation.
    pulse(8'h11);
    pulse(8'h22);
    check("abort_pre_state", int'(st[0]), 2);
    do_reset();
    @(negedge clk);
    check("abort_led", int'(led[0]), 0);
    check("abort_state", int'(st[0]), 0);
    check("abort_dropped", int'(dropped[0]), 0);
    run_op(8'd3, 8'd2, 8'd4, 8'd5, 1'b1, 1'b0);
    check("abort_next_re", got_re[0], 8'h16);
    check("abort_next_im", got_im[0], 8'hF9);

    for (int t = 0; t < 30; t++) begin
      r_ar = 8'($urandom_range(0, 255));
      r_ai = 8'($urandom_range(0, 255));
      r_qr = 8'($urandom_range(0, 255));
      r_qi = 8'($urandom_range(0, 255));
      r_cj = 1'($urandom_range(0, 1));
      run_op(r_ar, r_ai, r_qr, r_qi, r_cj, 1'b0);
      for (int k = 0; k < 3; k++) begin
        model(r_ar, r_ai, r_qr, r_qi, r_cj, k, mre, mim, more, moim);
        check($sformatf("rnd%0d_i%0d_re", t, k), got_re[k], mre);
        check($sformatf("rnd%0d_i%0d_im", t, k), got_im[k], mim);
        check($sformatf("rnd%0d_i%0d_ovf_re", t, k), got_ore[k], more);
        check($sformatf("rnd%0d_i%0d_ovf_im", t, k), got_oim[k], moim);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
